uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a byte FIFO. Frame format is latched when a byte is popped,
// so configuration inputs may change freely while a frame is on the line.
module uart_tx_cfg #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  input  logic [DIV_W-1:0]   baud_div,
  input  logic [1:0]         data_bits,
  input  logic [1:0]         parity_mode,
  input  logic               stop2,
  input  logic               send_break,
  output logic               tx,
  output logic               active,
  output logic               frame_done,
  output logic               fifo_full,
  output logic               fifo_empty,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DepthLvl = (FIFO_AW + 1)'(Depth);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------------------------
  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   level_q;
  logic               overflow_q;
  logic               push;
  logic               pop;

  assign fifo_full  = (level_q == DepthLvl);
  assign fifo_empty = (level_q == '0);
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign push = wr_en && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + FIFO_AW'(1);
      if (pop)  rptr_q <= rptr_q + FIFO_AW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + (FIFO_AW + 1)'(1);
        2'b01:   level_q <= level_q - (FIFO_AW + 1)'(1);
        default: level_q <= level_q;
      endcase
      overflow_q <= wr_en && !push;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  // ---------------------------------------------------------------------------------------------
  // Frame parameters derived from the head of the FIFO and the live configuration
  // ---------------------------------------------------------------------------------------------
  logic [7:0] head_byte;
  logic [7:0] head_mask;
  logic [2:0] head_last;
  logic       head_par;

  assign head_byte = mem_q[rptr_q];
  assign head_mask = 8'hFF >> (2'd3 - data_bits);
  assign head_last = {1'b0, data_bits} + 3'd4;

  always_comb begin
    head_par = 1'b1;
    unique case (parity_mode)
      2'b01:   head_par = ^(head_byte & head_mask);
      2'b10:   head_par = ~^(head_byte & head_mask);
      default: head_par = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       last_q, last_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             stop2_q, stop2_d;
  logic             stop_idx_q, stop_idx_d;
  logic             brk_stop_q, brk_stop_d;
  logic             bit_end;
  logic             start_frame;

  assign bit_end = (cnt_q == div_q);
  assign active  = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      last_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      brk_stop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      last_q     <= last_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      brk_stop_q <= brk_stop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (state_q == StIdle || bit_end) ? '0 : cnt_q + DIV_W'(1);
    div_d       = div_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    last_d      = last_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    stop2_d     = stop2_q;
    stop_idx_d  = stop_idx_q;
    brk_stop_d  = brk_stop_q;
    start_frame = 1'b0;
    tx          = 1'b1;
    frame_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (send_break) begin
          state_d    = StBreak;
          div_d      = baud_div;
          brk_stop_d = 1'b0;
          stop_idx_d = 1'b0;
        end else if (!fifo_empty) begin
          start_frame = 1'b1;
        end
      end
      StStart: begin
        tx = 1'b0;
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        tx = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == last_q) begin
            state_d    = par_en_q ? StParity : StStop;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StParity: begin
        tx = par_bit_q;
        if (bit_end) begin
          state_d    = StStop;
          stop_idx_d = 1'b0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop_idx_q == stop2_q) begin
            frame_done = 1'b1;
            if (!fifo_empty && !send_break) begin
              start_frame = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      StBreak: begin
        if (!brk_stop_q) begin
          // Line held low with the baud counter parked until the request drops.
          tx    = 1'b0;
          cnt_d = '0;
          if (!send_break) begin
            brk_stop_d = 1'b1;
            stop_idx_d = 1'b0;
          end
        end else if (bit_end) begin
          if (stop_idx_q) begin
            state_d    = StIdle;
            brk_stop_d = 1'b0;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_frame) begin
      state_d    = StStart;
      cnt_d      = '0;
      div_d      = baud_div;
      shift_d    = head_byte;
      bit_idx_d  = '0;
      last_d     = head_last;
      par_en_d   = (parity_mode != 2'b00);
      par_bit_d  = head_par;
      stop2_d    = stop2;
      stop_idx_d = 1'b0;
    end
  end

  assign pop = start_frame;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomised bench for uart_tx_cfg: each frame is predicted as a list of line bits built from the
// byte and format, then compared cycle by cycle against tx and frame_done.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        send_break;
  logic        tx;
  logic        active;
  logic        frame_done;
  logic        fifo_full;
  logic        fifo_empty;
  logic [4:0]  fifo_level;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_bits[$];

  uart_tx_cfg #(.DIV_W(16), .FIFO_AW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .baud_div    (baud_div),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .send_break  (send_break),
    .tx          (tx),
    .active      (active),
    .frame_done  (frame_done),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int div, input int db, input int pm, input int s2);
    baud_div    = 16'(div);
    data_bits   = 2'(db);
    parity_mode = 2'(pm);
    stop2       = 1'(s2);
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  // Line bits of one frame: start, data LSB first, optional parity, stop bit(s).
  task automatic build_frame(input logic [7:0] b, input int db, input int pm, input int s2);
    int n;
    int ones;
    n    = db + 5;
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (pm == 1) exp_bits.push_back(ones % 2 == 1);
    if (pm == 2) exp_bits.push_back(ones % 2 == 0);
    if (pm == 3) exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b1);
    if (s2 != 0) exp_bits.push_back(1'b1);
  endtask

  // Waits up to wait_max cycles for the start bit, then checks every cycle of the frame.
  task automatic check_frame(input logic [7:0] b, input int db, input int pm, input int s2,
                             input int div, input int wait_max, input bit scramble,
                             input string name);
    int w;
    int total;
    bit exp;
    bit exp_fd;
    w = 0;
    while (tx !== 1'b0 && w < wait_max) begin
      step();
      w++;
    end
    n_checks++;
    if (tx !== 1'b0) begin
      $display("FAIL %s start: tx=%b, required 0 within %0d cycles", name, tx, wait_max);
      n_fail++;
      return;
    end
    build_frame(b, db, pm, s2);
    total = exp_bits.size() * (div + 1);
    for (int k = 0; k < total; k++) begin
      exp    = exp_bits[k / (div + 1)];
      exp_fd = (k == total - 1);
      n_checks++;
      if (tx !== exp || frame_done !== exp_fd) begin
        $display("FAIL %s cycle %0d: tx=%b frame_done=%b, required tx=%b frame_done=%b",
                 name, k, tx, frame_done, exp, exp_fd);
        n_fail++;
      end
      if (scramble && k == 1) begin
        set_cfg($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1));
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if ({tx, active, frame_done, overflow, fifo_empty, fifo_full, fifo_level} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0}) begin
      $display("FAIL reset: tx=%b active=%b fd=%b ovf=%b empty=%b full=%b level=%0d, required 1 0 0 0 1 0 0",
               tx, active, frame_done, overflow, fifo_empty, fifo_full, fifo_level);
      n_fail++;
    end
  endtask

  task automatic test_basic();
    set_cfg(3, 3, 0, 0);
    push_byte(8'hA5);
    n_checks++;
    if (tx !== 1'b1) begin
      $display("FAIL basic latency: tx=%b one cycle after write, required 1", tx);
      n_fail++;
    end
    step();
    check_frame(8'hA5, 3, 0, 0, 3, 0, 1'b0, "basic");
    n_checks++;
    if (tx !== 1'b1 || active !== 1'b0) begin
      $display("FAIL basic idle: tx=%b active=%b, required 1 0", tx, active);
      n_fail++;
    end
  endtask

  task automatic test_parity();
    set_cfg(0, 2, 1, 1);
    push_byte(8'h55);
    check_frame(8'h55, 2, 1, 1, 0, 2, 1'b0, "parity_even");
    set_cfg(0, 2, 2, 1);
    push_byte(8'h55);
    check_frame(8'h55, 2, 2, 1, 0, 2, 1'b0, "parity_odd");
  endtask

  task automatic test_random();
    int div, db, pm, s2;
    logic [7:0] b;
    for (int i = 0; i < 24; i++) begin
      div = $urandom_range(0, 3);
      db  = $urandom_range(0, 3);
      pm  = $urandom_range(0, 3);
      s2  = $urandom_range(0, 1);
      b   = 8'($urandom);
      set_cfg(div, db, pm, s2);
      push_byte(b);
      check_frame(b, db, pm, s2, div, 2, 1'b1, "random");
      n_checks++;
      if (active !== 1'b0) begin
        $display("FAIL random idle: active=%b after frame %0d, required 0", active, i);
        n_fail++;
      end
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(1, 3, 0, 0);
    push_byte(8'h01);
    push_byte(8'h02);
    check_frame(8'h01, 3, 0, 0, 1, 1, 1'b0, "b2b_first");
    check_frame(8'h02, 3, 0, 0, 1, 0, 1'b0, "b2b_second");
    n_checks++;
    if (active !== 1'b0 || frame_done !== 1'b0) begin
      $display("FAIL b2b end: active=%b frame_done=%b, required 0 0", active, frame_done);
      n_fail++;
    end
  endtask

  task automatic test_overflow();
    logic [7:0] q[$];
    logic [7:0] b;
    int exp_lvl;
    int w;
    set_cfg(0, 3, 0, 0);
    send_break = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      wr_en   = 1'b1;
      wr_data = b;
      step();
      if (i < 16) q.push_back(b);
      exp_lvl = (i + 1 > 16) ? 16 : i + 1;
      n_checks++;
      if (overflow !== (i == 16) || fifo_level !== 5'(exp_lvl)) begin
        $display("FAIL overflow write %0d: overflow=%b level=%0d, required %b %0d",
                 i, overflow, fifo_level, (i == 16), exp_lvl);
        n_fail++;
      end
    end
    wr_en = 1'b0;
    n_checks++;
    if (fifo_full !== 1'b1 || fifo_empty !== 1'b0) begin
      $display("FAIL overflow full: full=%b empty=%b, required 1 0", fifo_full, fifo_empty);
      n_fail++;
    end
    step();
    n_checks++;
    if (overflow !== 1'b0) begin
      $display("FAIL overflow pulse: overflow=%b a cycle later, required 0", overflow);
      n_fail++;
    end
    send_break = 1'b0;
    w = 0;
    while (active !== 1'b0 && w < 20) begin
      step();
      w++;
    end
    n_checks++;
    if (active !== 1'b0) begin
      $display("FAIL overflow break end: active=%b, required 0 within 20 cycles", active);
      n_fail++;
    end
    // The idle cycle pops the head; push in the same cycle while full.
    b = 8'($urandom);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en = 1'b0;
    q.push_back(b);
    n_checks++;
    if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
      $display("FAIL overflow push_pop: level=%0d overflow=%b, required 16 0", fifo_level, overflow);
      n_fail++;
    end
    while (q.size() > 0) begin
      b = q.pop_front();
      check_frame(b, 3, 0, 0, 0, 0, 1'b0, "overflow_drain");
    end
    n_checks++;
    if (fifo_empty !== 1'b1 || fifo_level !== 5'd0 || active !== 1'b0) begin
      $display("FAIL overflow drained: empty=%b level=%0d active=%b, required 1 0 0",
               fifo_empty, fifo_level, active);
      n_fail++;
    end
  endtask

  task automatic test_break();
    set_cfg(3, 3, 0, 0);
    send_break = 1'b1;
    wr_en      = 1'b1;
    wr_data    = 8'h33;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      n_checks++;
      if (tx !== 1'b0 || active !== 1'b1) begin
        $display("FAIL break low %0d: tx=%b active=%b, required 0 1", i, tx, active);
        n_fail++;
      end
      if (i == 49) send_break = 1'b0;
      step();
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (tx !== 1'b1 || frame_done !== 1'b0) begin
        $display("FAIL break stop %0d: tx=%b frame_done=%b, required 1 0", i, tx, frame_done);
        n_fail++;
      end
      step();
    end
    check_frame(8'h33, 3, 0, 0, 3, 4, 1'b0, "break_frame");
  endtask

  task automatic test_reset_mid();
    int lows;
    set_cfg(3, 3, 0, 0);
    push_byte(8'hC3);
    push_byte(8'h5A);
    push_byte(8'h0F);
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (active !== 1'b1 || fifo_level !== 5'd2) begin
      $display("FAIL reset_mid pre: active=%b level=%0d, required 1 2", active, fifo_level);
      n_fail++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({tx, active, frame_done, overflow, fifo_empty, fifo_full, fifo_level} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0}) begin
      $display("FAIL reset_mid: tx=%b active=%b fd=%b ovf=%b empty=%b full=%b level=%0d, required 1 0 0 0 1 0 0",
               tx, active, frame_done, overflow, fifo_empty, fifo_full, fifo_level);
      n_fail++;
    end
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (tx !== 1'b1 || active !== 1'b0) lows++;
    end
    n_checks++;
    if (lows !== 0) begin
      $display("FAIL reset_mid quiet: %0d busy cycles after reset, required 0", lows);
      n_fail++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    send_break = 1'b0;
    set_cfg(0, 3, 0, 0);
    test_reset();
    test_basic();
    test_parity();
    test_random();
    test_back_to_back();
    test_overflow();
    test_break();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
